// File: rtl/aemb2_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// aemb2_pipe_ctrl
//
// Pipeline sequencer for the AEMB2 core. Sits beside the decode stage and
// fans the global enable and thread phase out to every pipeline register.
//
//   * ena_o  : global pipeline enable. Drops combinationally while either
//              Wishbone bus has an outstanding strobe without acknowledge.
//              A stall watchdog forces a single enabled cycle after
//              2^TMO_BITS consecutive stalled cycles (flagged on tmo_o).
//   * pha_o  : hardware-thread phase. Toggles on every enabled cycle while
//              multithreading is built in (TXE) and enabled (rMSR_TXE).
//   * rINT   : interrupt injection request to the decode mux. The external
//              interrupt is synchronised, optionally edge-latched, and only
//              injected into thread 0 outside a branch delay slot.
//
// Parameters
//   TXE       1 = hardware multithreading present, 0 = pha_o tied low
//   TMO_BITS  watchdog counter width
//   INT_EDGE  0 = level-sensitive interrupt, 1 = rising-edge latched
//
// Ports
//   clk_i      in   core clock
//   rst_i      in   synchronous active-high reset
//   iwb_stb_i  in   instruction bus request active
//   iwb_ack_i  in   instruction bus acknowledge
//   dwb_stb_i  in   data bus request active
//   dwb_ack_i  in   data bus acknowledge
//   sys_int_i  in   asynchronous external interrupt
//   rMSR_IE    in   MSR interrupt enable
//   rMSR_TXE   in   MSR thread-execution enable
//   rBRA       in   branch status from execute, nonzero = branch/delay slot
//   ena_o      out  pipeline enable (combinational)
//   pha_o      out  thread phase
//   rINT       out  interrupt injection request to decode
//   tmo_o      out  one-cycle watchdog timeout pulse
// ---------------------------------------------------------------------------
module aemb2_pipe_ctrl #(
  parameter int TXE      = 1,
  parameter int TMO_BITS = 8,
  parameter int INT_EDGE = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       iwb_stb_i,
  input  logic       iwb_ack_i,
  input  logic       dwb_stb_i,
  input  logic       dwb_ack_i,
  input  logic       sys_int_i,
  input  logic       rMSR_IE,
  input  logic       rMSR_TXE,
  input  logic [1:0] rBRA,
  output logic       ena_o,
  output logic       pha_o,
  output logic       rINT,
  output logic       tmo_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_INJ  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [TMO_BITS-1:0] CNT_MAX = {TMO_BITS{1'b1}};

  logic                stall;
  logic [TMO_BITS-1:0] cnt;

  logic                int_p0;
  logic                int_p1;
  logic                int_p2;
  logic                edge_seen;
  logic                edge_flag;
  logic                pend;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                inj_go;

  // Watchdog expiry: only meaningful on a stalled cycle.
  function automatic logic wdog_expired(input logic [TMO_BITS-1:0] c);
    return (c == CNT_MAX);
  endfunction

  // -------------------------------------------------------------------------
  // Enable: a bus strobe without acknowledge stalls the whole pipeline.
  // The registered timeout pulse punches one enabled cycle through a stall.
  // -------------------------------------------------------------------------
  assign stall = (iwb_stb_i & ~iwb_ack_i) | (dwb_stb_i & ~dwb_ack_i);
  assign ena_o = ~stall | tmo_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt   <= '0;
      tmo_o <= 1'b0;
    end else begin
      tmo_o <= 1'b0;
      if (ena_o) begin
        cnt <= '0;
      end else if (wdog_expired(cnt)) begin
        cnt   <= '0;
        tmo_o <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Thread phase: alternates threads on every enabled cycle, collapses to
  // thread 0 when thread execution is switched off in the MSR.
  // -------------------------------------------------------------------------
  generate
    if (TXE != 0) begin : g_txe
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          pha_o <= 1'b0;
        end else if (ena_o) begin
          pha_o <= rMSR_TXE ? ~pha_o : 1'b0;
        end
      end
    end else begin : g_no_txe
      assign pha_o = 1'b0;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Interrupt synchroniser stage p0 -> p1, then p2 for edge detection.
  // Runs every cycle, independent of the pipeline enable, so that edges are
  // never missed while the pipeline is stalled.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      int_p0 <= 1'b0;
      int_p1 <= 1'b0;
      int_p2 <= 1'b0;
    end else begin
      int_p0 <= sys_int_i;
      int_p1 <= int_p0;
      int_p2 <= int_p1;
    end
  end

  assign edge_seen = int_p1 & ~int_p2;

  // The flag is only ever cleared on the WAIT->INJ transition, so an edge
  // arriving while in INJ (or any other state) sets it for the next request.
  // An edge coinciding with the clear is absorbed by that injection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edge_flag <= 1'b0;
    end else if (inj_go) begin
      edge_flag <= 1'b0;
    end else if (edge_seen) begin
      edge_flag <= 1'b1;
    end
  end

  assign pend = (INT_EDGE != 0) ? edge_flag : int_p1;

  // -------------------------------------------------------------------------
  // Injection FSM, advancing only on enabled cycles (a forced timeout cycle
  // counts). Injection targets thread 0 and never lands in a delay slot.
  // HOLD waits for the handler to drop IE so one request yields one inject.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    inj_go    = 1'b0;
    if (ena_o) begin
      case (state)
        ST_IDLE: begin
          if (pend) state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (!pend) begin
            state_nxt = ST_IDLE;
          end else if (rMSR_IE && (rBRA == 2'b00) && !pha_o) begin
            state_nxt = ST_INJ;
            inj_go    = 1'b1;
          end
        end
        ST_INJ: begin
          state_nxt = ST_HOLD;
        end
        ST_HOLD: begin
          if (!rMSR_IE) state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // State is a register, so the request is glitch-free and persists across
  // stalls until the decode stage consumes it on an enabled cycle.
  assign rINT = (state == ST_INJ);

endmodule

// File: tb/tb_aemb2_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aemb2_pipe_ctrl
//
// Drives a level-mode and an edge-mode instance of aemb2_pipe_ctrl from the
// same inputs and compares all outputs every cycle against a behavioural
// reference model. Directed sequences cover reset, free-running phase, short
// and watchdog-length stalls, interrupt injection in both modes and reset
// during an injection; a randomized section follows.
// ---------------------------------------------------------------------------
module tb_aemb2_pipe_ctrl;

  localparam int TMO = 4;
  localparam int LIM = (1 << TMO) - 1;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_INJ  = 2;
  localparam int M_HOLD = 3;

  logic       clk;
  logic       rst;
  logic       iwb_stb, iwb_ack, dwb_stb, dwb_ack;
  logic       sys_int, msr_ie, msr_txe;
  logic [1:0] bra;
  logic [1:0] o_ena, o_pha, o_rint, o_tmo;

  int n_chk = 0;
  int n_err = 0;

  // model state, index 0 = level instance, 1 = edge instance
  bit m_tmo  [2];
  int m_run  [2];
  bit m_pha  [2];
  bit m_h0   [2];
  bit m_h1   [2];
  bit m_h2   [2];
  bit m_flag [2];
  int m_st   [2];

  // observation counters used by directed checks
  int n_tmo_seen;
  int n_ena_hi;
  int n_inj [2];
  int n_rint_hi [2];
  bit prev_rint [2];

  aemb2_pipe_ctrl #(.TXE(1), .TMO_BITS(TMO), .INT_EDGE(0)) dut_lvl (
    .clk_i(clk), .rst_i(rst),
    .iwb_stb_i(iwb_stb), .iwb_ack_i(iwb_ack),
    .dwb_stb_i(dwb_stb), .dwb_ack_i(dwb_ack),
    .sys_int_i(sys_int), .rMSR_IE(msr_ie), .rMSR_TXE(msr_txe), .rBRA(bra),
    .ena_o(o_ena[0]), .pha_o(o_pha[0]), .rINT(o_rint[0]), .tmo_o(o_tmo[0])
  );

  aemb2_pipe_ctrl #(.TXE(1), .TMO_BITS(TMO), .INT_EDGE(1)) dut_edg (
    .clk_i(clk), .rst_i(rst),
    .iwb_stb_i(iwb_stb), .iwb_ack_i(iwb_ack),
    .dwb_stb_i(dwb_stb), .dwb_ack_i(dwb_ack),
    .sys_int_i(sys_int), .rMSR_IE(msr_ie), .rMSR_TXE(msr_txe), .rBRA(bra),
    .ena_o(o_ena[1]), .pha_o(o_pha[1]), .rINT(o_rint[1]), .tmo_o(o_tmo[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bus_stall();
    return (iwb_stb && !iwb_ack) || (dwb_stb && !dwb_ack);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_tmo[d] = 0; m_run[d] = 0; m_pha[d] = 0;
      m_h0[d] = 0; m_h1[d] = 0; m_h2[d] = 0;
      m_flag[d] = 0; m_st[d] = M_IDLE;
      prev_rint[d] = 0;
    end
  endtask

  task automatic compare_all();
    bit st;
    st = bus_stall();
    for (int d = 0; d < 2; d++) begin
      check_val(d ? "edg_ena" : "lvl_ena", o_ena[d], !st || m_tmo[d]);
      check_val(d ? "edg_pha" : "lvl_pha", o_pha[d], m_pha[d]);
      check_val(d ? "edg_rint" : "lvl_rint", o_rint[d], m_st[d] == M_INJ);
      check_val(d ? "edg_tmo" : "lvl_tmo", o_tmo[d], m_tmo[d]);
      if (o_rint[d] && !prev_rint[d]) n_inj[d]++;
      if (o_rint[d]) n_rint_hi[d]++;
      prev_rint[d] = o_rint[d];
    end
    if (o_tmo[0]) n_tmo_seen++;
    if (o_ena[0]) n_ena_hi++;
  endtask

  task automatic model_next();
    bit st, en, pend, rising, take;
    st = bus_stall();
    for (int d = 0; d < 2; d++) begin
      en = !st || m_tmo[d];
      if (rst) begin
        m_tmo[d] = 0; m_run[d] = 0; m_pha[d] = 0;
        m_h0[d] = 0; m_h1[d] = 0; m_h2[d] = 0;
        m_flag[d] = 0; m_st[d] = M_IDLE;
      end else begin
        pend   = (d == 1) ? m_flag[d] : m_h1[d];
        rising = m_h1[d] && !m_h2[d];
        take   = 0;
        if (en) begin
          case (m_st[d])
            M_IDLE: if (pend) m_st[d] = M_WAIT;
            M_WAIT: begin
              if (!pend) m_st[d] = M_IDLE;
              else if (msr_ie && bra == 2'b00 && !m_pha[d]) begin
                m_st[d] = M_INJ;
                take = 1;
              end
            end
            M_INJ:  m_st[d] = M_HOLD;
            default: if (!msr_ie) m_st[d] = M_IDLE;
          endcase
          m_pha[d] = msr_txe ? !m_pha[d] : 1'b0;
        end
        if (take) m_flag[d] = 0;
        else if (rising) m_flag[d] = 1;
        m_h2[d] = m_h1[d];
        m_h1[d] = m_h0[d];
        m_h0[d] = sys_int;
        if (en) begin
          m_run[d] = 0; m_tmo[d] = 0;
        end else if (m_run[d] == LIM) begin
          m_run[d] = 0; m_tmo[d] = 1;
        end else begin
          m_run[d] = m_run[d] + 1; m_tmo[d] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    iwb_stb = 0; iwb_ack = 0; dwb_stb = 0; dwb_ack = 0;
    sys_int = 0; msr_ie = 0; msr_txe = 1; bra = 2'b00;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    for (int i = 0; i < n; i++) tick();
    rst = 0;
  endtask

  initial begin
    model_reset();
    quiet();
    rst = 1;
    iwb_stb = 1; iwb_ack = 0;   // ena during reset follows the bus only
    tick();
    quiet();
    do_reset(2);

    // free-running phase: pha toggles every cycle
    for (int i = 0; i < 6; i++) tick();

    // short data-bus stall, phase frozen, no timeout
    n_tmo_seen = 0;
    dwb_stb = 1; dwb_ack = 0;
    for (int i = 0; i < 3; i++) tick();
    dwb_ack = 1;
    tick();
    dwb_stb = 0; dwb_ack = 0;
    tick();
    check_val("short_stall_tmo", n_tmo_seen, 0);

    // thread execution disabled: phase collapses to 0
    msr_txe = 0;
    for (int i = 0; i < 3; i++) tick();
    msr_txe = 1;

    // watchdog: 20 stalled cycles, one forced release at cycle 17
    n_tmo_seen = 0; n_ena_hi = 0;
    iwb_stb = 1; iwb_ack = 0;
    for (int i = 0; i < 20; i++) tick();
    check_val("wdog_tmo_count", n_tmo_seen, 1);
    check_val("wdog_ena_count", n_ena_hi, 1);
    iwb_stb = 0;
    tick();

    // level interrupt, clean injection
    quiet(); do_reset(1);
    n_inj[0] = 0; n_rint_hi[0] = 0;
    sys_int = 1; msr_ie = 1;
    for (int i = 0; i < 12; i++) tick();
    check_val("lvl_inj_once", n_inj[0], 1);
    check_val("lvl_rint_width", n_rint_hi[0], 1);
    msr_ie = 0; sys_int = 0;
    for (int i = 0; i < 5; i++) tick();

    // level interrupt during a branch: deferred until rBRA clears
    n_inj[0] = 0;
    sys_int = 1; msr_ie = 1; bra = 2'd2;
    for (int i = 0; i < 10; i++) tick();
    check_val("lvl_bra_defer", n_inj[0], 0);
    bra = 2'd0;
    for (int i = 0; i < 6; i++) tick();
    check_val("lvl_bra_release", n_inj[0], 1);
    msr_ie = 0; sys_int = 0;
    for (int i = 0; i < 5; i++) tick();

    // edge interrupt: short pulse with IE off, then a single injection
    quiet(); do_reset(1);
    for (int i = 0; i < 3; i++) tick();
    n_inj[1] = 0;
    sys_int = 1; tick(); sys_int = 0;
    for (int i = 0; i < 10; i++) tick();
    check_val("edg_wait_no_ie", n_inj[1], 0);
    msr_ie = 1;
    for (int i = 0; i < 10; i++) tick();
    check_val("edg_inj_once", n_inj[1], 1);
    msr_ie = 0;
    for (int i = 0; i < 5; i++) tick();
    msr_ie = 1;
    for (int i = 0; i < 10; i++) tick();
    check_val("edg_no_second", n_inj[1], 1);

    // reset while injecting with a stall active
    quiet(); do_reset(1);
    sys_int = 1; msr_ie = 1;
    for (int i = 0; i < 30 && m_st[0] != M_INJ; i++) tick();
    check_val("reach_inj", o_rint[0], 1);
    iwb_stb = 1; iwb_ack = 0;
    tick();
    check_val("inj_held_stall", o_rint[0], 1);
    rst = 1;
    tick();
    rst = 0;
    check_val("rst_rint", o_rint[0], 0);
    check_val("rst_pha", o_pha[0], 0);
    check_val("rst_tmo", o_tmo[0], 0);
    tick();
    quiet();
    tick();

    // randomized blocks
    for (int b = 0; b < 40; b++) begin
      int mode, len;
      mode = $urandom_range(0, 3);
      len  = $urandom_range(6, 24);
      msr_ie  = ($urandom_range(0, 3) != 0);
      msr_txe = ($urandom_range(0, 5) != 0);
      for (int i = 0; i < len; i++) begin
        rst = ($urandom_range(0, 99) == 0);
        case (mode)
          0: begin iwb_stb = 0; dwb_stb = 0; end
          1: begin
            iwb_stb = $urandom_range(0, 1); iwb_ack = ($urandom_range(0, 2) != 0);
            dwb_stb = $urandom_range(0, 1); dwb_ack = ($urandom_range(0, 2) != 0);
          end
          2: begin iwb_stb = 1; iwb_ack = 0; dwb_stb = 0; end
          default: begin
            iwb_stb = $urandom_range(0, 1); iwb_ack = $urandom_range(0, 1);
            dwb_stb = 1; dwb_ack = ($urandom_range(0, 7) == 0);
          end
        endcase
        if ($urandom_range(0, 5) == 0) sys_int = ~sys_int;
        bra = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        if ($urandom_range(0, 15) == 0) msr_ie = ~msr_ie;
        tick();
      end
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
